gen_video_pattern: RTL
======================

Name: gen_video_pattern

Overview:
- Parametrised successor to the single-mode rainbow/border pixel generator.
- Produces a registered 24-bit RGB value for pixel (pixX,pixY) in one of several selectable test patterns: solid rotating colour, colour bars, animated bars, checkerboard, gradient.
- Adds an optional border overlay and blanking outside the active area.
- Sits between the video timing generator and the TMDS/HDMI encoder.

Parameters:
X_BITWIDTH, 12, width of pixX/screenWidth
Y_BITWIDTH, 11, width of pixY/screenHeight
DWELL_BITS, 25, width of the colour-rotation dwell counter
DWELL_MAX, 2**DWELL_BITS-1, dwell counter terminal value; colour advances every DWELL_MAX+1 unfrozen cycles
CHECKER_LOG2, 5, checkerboard square size is 2**CHECKER_LOG2 pixels
BORDER_COLOR, 24'h0000ff, overlay colour for the 1-pixel frame border

Ports:
I_clk_pixel  in  1  pixel clock
I_reset_n  in  1  asynchronous active-low reset
pixX  in  X_BITWIDTH  current pixel column
pixY  in  Y_BITWIDTH  current pixel row
screenWidth  in  X_BITWIDTH  active width, >=8
screenHeight  in  Y_BITWIDTH  active height, >=2
I_frame_start  in  1  one-cycle pulse, first pixel of a frame
I_mode  in  3  requested pattern, sampled only at I_frame_start
I_border_en  in  1  enable border overlay
I_freeze  in  1  hold dwell counter and colour index
rgb  out  24  registered pixel colour {R,G,B}
O_mode  out  3  currently active mode
O_color_idx  out  3  current rotation index
O_frame_cnt  out  8  frame counter

Behaviour:
- Reset (async, I_reset_n low): rgb=0, O_mode=0, O_color_idx=0, O_frame_cnt=0, dwell counter=0. Outputs hold while reset is low. Normal operation resumes on the first clock edge after release.
- Latency: exactly 1 cycle. rgb at edge N+1 reflects the inputs sampled at edge N.
- Fixed palette, index 0..7: ff0000, 00ff00, ffff00, 0000ff, ff00ff, 00ffff, ffffff, ff9900.
- Dwell/rotation:
  - When I_freeze=0, the dwell counter increments each cycle.
  - At DWELL_MAX the dwell counter wraps to 0 and color_idx advances mod 8 (7->0).
  - I_freeze=1 holds both; freeze wins over a simultaneous wrap.
- Frame counter: on I_frame_start, O_frame_cnt increments mod 256.
- Mode latch:
  - On I_frame_start, the mode register loads I_mode. The effective mode for that same cycle's pixel is I_mode.
  - At all other times the effective mode is the register. Mid-frame changes on I_mode are ignored.
- Bar thresholds:
  - T_k = (k*screenWidth)>>3 for k=1..7. Use constant shift-add multiplies; no divider.
  - bar = number of T_k <= pixX, range 0..7.
- Colour by effective mode:
  - 0: palette[color_idx] on every pixel.
  - 1: palette[bar].
  - 2: palette[(bar+color_idx) mod 8] (bars scroll with rotation).
  - 3: ffffff if pixX[CHECKER_LOG2]^pixY[CHECKER_LOG2], else 000000.
  - 4: {pixX[7:0], pixY[7:0], O_frame_cnt}.
  - 5..7: 000000. The invalid value is still latched and reported on O_mode.
- Priority, highest first:
  1. Blank: pixX>=screenWidth or pixY>=screenHeight gives 000000.
  2. Border: I_border_en and (pixX==0 or pixX==screenWidth-1 or pixY==0 or pixY==screenHeight-1) gives BORDER_COLOR.
  3. Mode colour.
- Width rules:
  - screenWidth-1 and screenHeight-1 are computed at the port width.
  - k*screenWidth uses X_BITWIDTH+3 bits before the shift.
  - All counters wrap silently.

Test Plan:
- Reset mid-frame with DWELL_MAX=3 and counters nonzero: assert I_reset_n=0 -> rgb=0, O_color_idx=0, O_frame_cnt=0 immediately (async); after release and 4 clocks, O_color_idx=1.
- Rotation with DWELL_MAX=3, mode 0: rgb sequence ff0000 x4, 00ff00 x4, ... ff9900 x4, then ff0000 (wrap). Raising I_freeze mid-dwell holds the colour indefinitely.
- Colour bars, mode 1, screenWidth=640, border off: pixX=79 -> ff0000; 80 -> 00ff00; 559 -> ffffff; 560..639 -> ff9900. Each response appears 1 cycle after the input.
- Border and blanking, mode 3, screenWidth=640, screenHeight=480, border on: (0,100), (639,5), (10,479) -> 0000ff; (640,0) and (0,480) -> 000000; (32,0) -> 0000ff; (32,1) -> ffffff.
- Mode latch: I_mode=1 with no frame_start -> O_mode stays 0. Pulse I_frame_start with I_mode=4 at (0,0) -> rgb {00,00,frame_cnt+1} next cycle, O_mode=4. Then I_mode=6 at frame_start -> rgb 000000 everywhere off-border.
- Animated bars, mode 2, color_idx=3, screenWidth=640: pixX=0 -> palette[3]=0000ff; pixX=600 -> palette[(7+3) mod 8]=ffff00.

Source files
------------

// File: rtl/gen_video_pattern.sv
// Test-pattern pixel generator: registered 24-bit RGB for pixel (pixX,pixY).
// Supports rotating solid colour, static and scrolling bars, checkerboard, gradient, border and blanking.
module gen_video_pattern #(
   parameter int                    X_BITWIDTH   = 12,
   parameter int                    Y_BITWIDTH   = 11,
   parameter int                    DWELL_BITS   = 25,
   parameter logic [DWELL_BITS-1:0] DWELL_MAX    = {DWELL_BITS{1'b1}},
   parameter int                    CHECKER_LOG2 = 5,
   parameter logic [23:0]           BORDER_COLOR = 24'h0000ff
) (
   input  logic                  I_clk_pixel,
   input  logic                  I_reset_n,
   input  logic [X_BITWIDTH-1:0] pixX,
   input  logic [Y_BITWIDTH-1:0] pixY,
   input  logic [X_BITWIDTH-1:0] screenWidth,
   input  logic [Y_BITWIDTH-1:0] screenHeight,
   input  logic                  I_frame_start,
   input  logic [2:0]            I_mode,
   input  logic                  I_border_en,
   input  logic                  I_freeze,
   output logic [23:0]           rgb,
   output logic [2:0]            O_mode,
   output logic [2:0]            O_color_idx,
   output logic [7:0]            O_frame_cnt
);

   localparam logic [2:0] MODE_SOLID   = 3'd0;
   localparam logic [2:0] MODE_BARS    = 3'd1;
   localparam logic [2:0] MODE_SCROLL  = 3'd2;
   localparam logic [2:0] MODE_CHECKER = 3'd3;
   localparam logic [2:0] MODE_GRAD    = 3'd4;

   localparam logic [X_BITWIDTH-1:0] X_ONE     = 1;
   localparam logic [Y_BITWIDTH-1:0] Y_ONE     = 1;
   localparam logic [DWELL_BITS-1:0] DWELL_ONE = 1;

   function automatic logic [23:0] palette(input logic [2:0] idx);
      case (idx)
         3'd0:    palette = 24'hff0000;
         3'd1:    palette = 24'h00ff00;
         3'd2:    palette = 24'hffff00;
         3'd3:    palette = 24'h0000ff;
         3'd4:    palette = 24'hff00ff;
         3'd5:    palette = 24'h00ffff;
         3'd6:    palette = 24'hffffff;
         default: palette = 24'hff9900;
      endcase
   endfunction

   logic [DWELL_BITS-1:0] dwell_q;
   logic [2:0]            mode_q;
   logic [2:0]            color_idx_q;
   logic [7:0]            frame_cnt_q;

   logic [2:0]            mode_eff;
   logic [7:0]            frame_next;
   logic [7:0]            frame_eff;
   logic [X_BITWIDTH-1:0] width_m1;
   logic [Y_BITWIDTH-1:0] height_m1;
   logic [X_BITWIDTH+2:0] width_ext;
   logic [2:0]            bar;
   logic                  blank;
   logic                  on_border;
   logic [23:0]           mode_rgb;
   logic [23:0]           rgb_next;

   // A frame-start pixel already uses the newly requested mode and the incremented frame count.
   assign frame_next = frame_cnt_q + 8'd1;
   assign mode_eff   = I_frame_start ? I_mode : mode_q;
   assign frame_eff  = I_frame_start ? frame_next : frame_cnt_q;

   assign width_m1  = screenWidth - X_ONE;
   assign height_m1 = screenHeight - Y_ONE;
   assign width_ext = {3'b000, screenWidth};

   // Threshold k*W/8 built from shifted copies of W selected by the bits of the constant k.
   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      logic [X_BITWIDTH+2:0] prod;
      logic [X_BITWIDTH-1:0] thr;
      bar = 3'd0;
      for (int k = 1; k < 8; k++) begin
         prod = '0;
         if (k[0]) prod = prod + width_ext;
         if (k[1]) prod = prod + (width_ext << 1);
         if (k[2]) prod = prod + (width_ext << 2);
         thr = prod[X_BITWIDTH+2:3];
         if (thr <= pixX) bar = bar + 3'd1;
      end
   end

   assign blank     = (pixX >= screenWidth) || (pixY >= screenHeight);
   assign on_border = I_border_en &&
                      ((pixX == '0) || (pixX == width_m1) ||
                       (pixY == '0) || (pixY == height_m1));

   always_comb begin
      mode_rgb = 24'h000000;
      case (mode_eff)
         MODE_SOLID:   mode_rgb = palette(color_idx_q);
         MODE_BARS:    mode_rgb = palette(bar);
         MODE_SCROLL:  mode_rgb = palette(bar + color_idx_q);
         MODE_CHECKER: mode_rgb = (pixX[CHECKER_LOG2] ^ pixY[CHECKER_LOG2]) ? 24'hffffff : 24'h000000;
         MODE_GRAD:    mode_rgb = {pixX[7:0], pixY[7:0], frame_eff};
         default:      mode_rgb = 24'h000000;
      endcase
   end

   always_comb begin
      rgb_next = mode_rgb;
      if (blank)
         rgb_next = 24'h000000;
      else if (on_border)
         rgb_next = BORDER_COLOR;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge I_clk_pixel or negedge I_reset_n) begin
      if (!I_reset_n) begin
         rgb         <= 24'h000000;
         mode_q      <= 3'd0;
         color_idx_q <= 3'd0;
         frame_cnt_q <= 8'd0;
         dwell_q     <= '0;
      end else begin
         rgb <= rgb_next;
         if (I_frame_start) begin
            mode_q      <= I_mode;
            frame_cnt_q <= frame_next;
         end
         // Freeze takes precedence over a terminal-count wrap.
         if (!I_freeze) begin
            if (dwell_q == DWELL_MAX) begin
               dwell_q     <= '0;
               color_idx_q <= color_idx_q + 3'd1;
            end else begin
               dwell_q <= dwell_q + DWELL_ONE;
            end
         end
      end
   end

   assign O_mode      = mode_q;
   assign O_color_idx = color_idx_q;
   assign O_frame_cnt = frame_cnt_q;

endmodule
